// File: rtl/cpu_sequencer.sv
// Five-step microcode sequencer (T0-T4) with HALT; drives the full datapath control word.
// Optional conditional jumps (JC/JZ) are enabled by defining COND_JUMP_EN.
module cpu_sequencer #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           flag_c,
    input  logic           flag_z,
    output logic           pc_p_en,
    output logic           pc_t_en,
    output logic           pc_ld_n,
    output logic           pc_clr_n,
    output logic           pc_out,
    output logic           mar_in,
    output logic           ram_out,
    output logic           ram_in,
    output logic           ir_in,
    output logic           ir_out,
    output logic           a_in,
    output logic           a_out,
    output logic           b_in,
    output logic           alu_out,
    output logic           alu_sub,
    output logic           flags_in,
    output logic           out_in,
    output logic [2:0]     t_state,
    output logic           halted
);

    typedef enum logic {
        STEP,
        HALT
    } state_t;

    localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_STA = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_LDI = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(4'h6);
`ifdef COND_JUMP_EN
    localparam logic [OPW-1:0] OP_JC  = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h8);
`endif
    localparam logic [OPW-1:0] OP_OUT = OPW'(4'hE);
    localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

    state_t     state;
    logic [2:0] step;

`ifndef COND_JUMP_EN
    logic unused_flags;
    assign unused_flags = flag_c ^ flag_z;
`endif

    // HALT is entered from T2 and keeps step at 2, so t_state reads 2 while halted.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= STEP;
            step  <= '0;
        end else if (run && state == STEP) begin
            if (step == 3'd2 && opcode == OP_HLT) begin
                state <= HALT;
            end else if (step == 3'd4) begin
                step <= '0;
            end else begin
                step <= step + 3'd1;
            end
        end
    end

    // clr gates the visible step and halt flag immediately, not just after the edge.
    assign t_state = clr ? 3'd0 : step;
    assign halted  = (state == HALT) && !clr;

    always_comb begin
        pc_p_en  = 1'b0;
        pc_t_en  = 1'b0;
        pc_ld_n  = 1'b1;
        pc_clr_n = 1'b1;
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        ram_out  = 1'b0;
        ram_in   = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        flags_in = 1'b0;
        out_in   = 1'b0;
        if (clr) begin
            pc_clr_n = 1'b0;
        end else if (state == STEP && run) begin
            case (step)
                3'd0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                3'd1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_p_en = 1'b1;
                    pc_t_en = 1'b1;
                end
                3'd2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_ld_n = 1'b0;
                        end
`ifdef COND_JUMP_EN
                        OP_JC: begin
                            if (flag_c) begin
                                ir_out  = 1'b1;
                                pc_ld_n = 1'b0;
                            end
                        end
                        OP_JZ: begin
                            if (flag_z) begin
                                ir_out  = 1'b1;
                                pc_ld_n = 1'b0;
                            end
                        end
`endif
                        OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out  = 1'b1;
                        a_in     = 1'b1;
                        flags_in = 1'b1;
                        alu_sub  = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: the driver queues hand-written expected control
// words per cycle; a negedge monitor pops and compares them against the DUT outputs.
module tb_cpu_sequencer;

    localparam logic [16:0] PEN     = 17'h1 << 16;
    localparam logic [16:0] TEN     = 17'h1 << 15;
    localparam logic [16:0] LDN     = 17'h1 << 14;
    localparam logic [16:0] CLRN    = 17'h1 << 13;
    localparam logic [16:0] PCOUT   = 17'h1 << 12;
    localparam logic [16:0] MARIN   = 17'h1 << 11;
    localparam logic [16:0] RAMOUT  = 17'h1 << 10;
    localparam logic [16:0] RAMIN   = 17'h1 << 9;
    localparam logic [16:0] IRIN    = 17'h1 << 8;
    localparam logic [16:0] IROUT   = 17'h1 << 7;
    localparam logic [16:0] AIN     = 17'h1 << 6;
    localparam logic [16:0] AOUT    = 17'h1 << 5;
    localparam logic [16:0] BIN     = 17'h1 << 4;
    localparam logic [16:0] ALUOUT  = 17'h1 << 3;
    localparam logic [16:0] ALUSUB  = 17'h1 << 2;
    localparam logic [16:0] FLAGSIN = 17'h1 << 1;
    localparam logic [16:0] OUTIN   = 17'h1 << 0;

    localparam logic [16:0] IDLE  = LDN | CLRN;
    localparam logic [16:0] CLRW  = LDN;
    localparam logic [16:0] T0W   = PCOUT | MARIN | IDLE;
    localparam logic [16:0] T1W   = RAMOUT | IRIN | PEN | TEN | IDLE;
    localparam logic [16:0] JUMPW = IROUT | CLRN;
`ifdef COND_JUMP_EN
    localparam logic [16:0] CJUMPW = JUMPW;
`else
    localparam logic [16:0] CJUMPW = IDLE;
`endif

    typedef struct {
        logic [20:0] exp;
        string       name;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       clr, run, flag_c, flag_z;
    logic [3:0] opcode;
    logic pc_p_en, pc_t_en, pc_ld_n, pc_clr_n, pc_out, mar_in, ram_out, ram_in;
    logic ir_in, ir_out, a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in;
    logic [2:0] t_state;
    logic       halted;

    sb_item_t sb[$];
    int unsigned compared = 0;
    int unsigned failed   = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.OPW(4)) dut (
        .clk(clk), .clr(clr), .run(run), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z),
        .pc_p_en(pc_p_en), .pc_t_en(pc_t_en), .pc_ld_n(pc_ld_n), .pc_clr_n(pc_clr_n),
        .pc_out(pc_out), .mar_in(mar_in), .ram_out(ram_out), .ram_in(ram_in),
        .ir_in(ir_in), .ir_out(ir_out), .a_in(a_in), .a_out(a_out), .b_in(b_in),
        .alu_out(alu_out), .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in),
        .t_state(t_state), .halted(halted)
    );

    logic [20:0] actual;
    assign actual = {t_state, halted, pc_p_en, pc_t_en, pc_ld_n, pc_clr_n, pc_out, mar_in,
                     ram_out, ram_in, ir_in, ir_out, a_in, a_out, b_in, alu_out, alu_sub,
                     flags_in, out_in};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_item_t e;
            e = sb.pop_front();
            compared++;
            if (actual !== e.exp) begin
                failed++;
                $display("FAIL %s: got ts=%0d halted=%b cw=%05h, required ts=%0d halted=%b cw=%05h",
                         e.name, actual[20:18], actual[17], actual[16:0],
                         e.exp[20:18], e.exp[17], e.exp[16:0]);
            end
        end
    end

    task automatic cyc(input logic c, input logic r, input logic [3:0] op,
                       input logic fc, input logic fz, input logic [2:0] ts,
                       input logic h, input logic [16:0] w, input string nm);
        sb_item_t it;
        clr = c; run = r; opcode = op; flag_c = fc; flag_z = fz;
        it.exp  = {ts, h, w};
        it.name = nm;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic fc, input logic fz,
                         input logic [16:0] w2, input logic [16:0] w3,
                         input logic [16:0] w4, input string nm);
        cyc(0, 1, op, fc, fz, 3'd0, 0, T0W, {nm, "_t0"});
        cyc(0, 1, op, fc, fz, 3'd1, 0, T1W, {nm, "_t1"});
        cyc(0, 1, op, fc, fz, 3'd2, 0, w2,  {nm, "_t2"});
        cyc(0, 1, op, fc, fz, 3'd3, 0, w3,  {nm, "_t3"});
        cyc(0, 1, op, fc, fz, 3'd4, 0, w4,  {nm, "_t4"});
    endtask

    initial begin
        clr = 1; run = 1; opcode = 4'h0; flag_c = 0; flag_z = 0;
        @(posedge clk);
        #1;
        // reset held two cycles with run high
        cyc(1, 1, 4'h0, 0, 0, 3'd0, 0, CLRW, "reset0");
        cyc(1, 1, 4'h0, 0, 0, 3'd0, 0, CLRW, "reset1");
        instr(4'h0, 0, 0, IDLE, IDLE, IDLE, "nop");
        instr(4'h0, 0, 0, IDLE, IDLE, IDLE, "nop2");
        instr(4'h1, 0, 0, IROUT | MARIN | IDLE, RAMOUT | AIN | IDLE, IDLE, "lda");
        instr(4'h2, 0, 0, IROUT | MARIN | IDLE, RAMOUT | BIN | IDLE,
              ALUOUT | AIN | FLAGSIN | IDLE, "add");
        instr(4'h3, 0, 0, IROUT | MARIN | IDLE, RAMOUT | BIN | IDLE,
              ALUOUT | AIN | FLAGSIN | ALUSUB | IDLE, "sub");
        instr(4'h4, 0, 0, IROUT | MARIN | IDLE, AOUT | RAMIN | IDLE, IDLE, "sta");
        instr(4'h5, 0, 0, IROUT | AIN | IDLE, IDLE, IDLE, "ldi");
        instr(4'h6, 0, 0, JUMPW, IDLE, IDLE, "jmp");
        instr(4'hE, 0, 0, AOUT | OUTIN | IDLE, IDLE, IDLE, "out");
        instr(4'hB, 1, 1, IDLE, IDLE, IDLE, "nop_b");
        instr(4'h8, 0, 0, IDLE, IDLE, IDLE, "jz_nz");
        instr(4'h8, 1, 0, IDLE, IDLE, IDLE, "jz_c_only");
        instr(4'h8, 0, 1, CJUMPW, IDLE, IDLE, "jz_z");
        instr(4'h7, 0, 0, IDLE, IDLE, IDLE, "jc_nc");
        instr(4'h7, 1, 0, CJUMPW, IDLE, IDLE, "jc_c");
        // zero flag rising during T2 takes effect in that same cycle
        cyc(0, 1, 4'h8, 0, 0, 3'd0, 0, T0W, "jzlate_t0");
        cyc(0, 1, 4'h8, 0, 0, 3'd1, 0, T1W, "jzlate_t1");
        cyc(0, 1, 4'h8, 0, 1, 3'd2, 0, CJUMPW, "jzlate_t2");
        cyc(0, 1, 4'h8, 0, 1, 3'd3, 0, IDLE, "jzlate_t3");
        cyc(0, 1, 4'h8, 0, 1, 3'd4, 0, IDLE, "jzlate_t4");
        // stall in T1: step held, PC enables stay low, one increment on resume
        cyc(0, 1, 4'h0, 0, 0, 3'd0, 0, T0W, "stall_t0");
        cyc(0, 0, 4'h0, 0, 0, 3'd1, 0, IDLE, "stall_a");
        cyc(0, 0, 4'h0, 0, 0, 3'd1, 0, IDLE, "stall_b");
        cyc(0, 0, 4'h0, 0, 0, 3'd1, 0, IDLE, "stall_c");
        cyc(0, 1, 4'h0, 0, 0, 3'd1, 0, T1W, "stall_t1");
        cyc(0, 1, 4'h0, 0, 0, 3'd2, 0, IDLE, "stall_t2");
        cyc(0, 1, 4'h0, 0, 0, 3'd3, 0, IDLE, "stall_t3");
        cyc(0, 1, 4'h0, 0, 0, 3'd4, 0, IDLE, "stall_t4");
        // stall inside ADD execute
        cyc(0, 1, 4'h2, 0, 0, 3'd0, 0, T0W, "addst_t0");
        cyc(0, 1, 4'h2, 0, 0, 3'd1, 0, T1W, "addst_t1");
        cyc(0, 0, 4'h2, 0, 0, 3'd2, 0, IDLE, "addst_hold");
        cyc(0, 1, 4'h2, 0, 0, 3'd2, 0, IROUT | MARIN | IDLE, "addst_t2");
        // clr in the middle of an instruction
        cyc(1, 1, 4'h2, 0, 0, 3'd0, 0, CLRW, "midclr");
        instr(4'h0, 0, 0, IDLE, IDLE, IDLE, "after_midclr");
        // halt
        cyc(0, 1, 4'hF, 0, 0, 3'd0, 0, T0W, "hlt_t0");
        cyc(0, 1, 4'hF, 0, 0, 3'd1, 0, T1W, "hlt_t1");
        cyc(0, 1, 4'hF, 0, 0, 3'd2, 0, IDLE, "hlt_t2");
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 4'hF, 1, 1, 3'd2, 1, IDLE, "halted");
        cyc(0, 0, 4'h2, 0, 0, 3'd2, 1, IDLE, "halted_norun");
        cyc(0, 1, 4'h2, 0, 0, 3'd2, 1, IDLE, "halted_add");
        cyc(1, 1, 4'hF, 0, 0, 3'd0, 0, CLRW, "halt_clr");
        instr(4'h0, 0, 0, IDLE, IDLE, IDLE, "after_halt");
        cyc(0, 1, 4'h0, 0, 0, 3'd0, 0, T0W, "wrap_t0");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            compared++;
            failed++;
            $display("FAIL drain: got %0d pending entries, required 0", sb.size());
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
